tdc_hit_merger: RTL and testbench

TDC_HIT_MERGER -- requirements
Module: tdc_hit_merger

---
 rtl/tdc_hit_merger.sv | 170 +++++++++++++++++
 tb/tb_tdc_hit_merger.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_hit_merger.sv
// TDC hit merger: synchronizes per-channel hit pulses, waits for each channel's decode
// buses to settle, captures them and merges all channels onto one valid/ready stream.
module tdc_hit_merger #(
    parameter int N_CH   = 4,
    parameter int W_DEC  = 8,
    parameter int SETTLE = 15,
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int W_OUT = CH_W + 3 * W_DEC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic [N_CH-1:0]       hit,
    input  logic [N_CH*W_DEC-1:0] fall_edge,
    input  logic [N_CH*W_DEC-1:0] start_edge,
    input  logic [N_CH*W_DEC-1:0] coarse,
    output logic [W_OUT-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           drop_cnt
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_PEND} chState_t;

    localparam logic [CH_W-1:0] LAST_RESET  = CH_W'(N_CH - 1);
    localparam logic [7:0]      CAPTURE_CNT = 8'(SETTLE - 1);

    logic [N_CH-1:0]    sync1_q, sync2_q, hitPrev_q, hitRise;
    chState_t           state_q [N_CH];
    chState_t           state_d [N_CH];
    logic [7:0]         cnt_q [N_CH];
    logic [7:0]         cnt_d [N_CH];
    logic [3*W_DEC-1:0] hold_q [N_CH];
    logic [3*W_DEC-1:0] hold_d [N_CH];
    logic [W_OUT-1:0]   outData_q, outData_d;
    logic               outValid_q, outValid_d;
    logic [15:0]        dropCnt_q, dropCnt_d;
    logic [CH_W-1:0]    lastGrant_q, lastGrant_d, grantIdx;
    logic               grantFound, loadOut;
    logic [N_CH-1:0]    dropVec;
    logic [4:0]         dropPop;
    logic [16:0]        dropSum;
    int                 searchIdx;

    // Hit synchronizers and edge detector; clr deliberately leaves these alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            hitPrev_q <= '0;
        end else begin
            sync1_q   <= hit;
            sync2_q   <= sync1_q;
            hitPrev_q <= sync2_q;
        end
    end

    assign hitRise = sync2_q & ~hitPrev_q;
    assign loadOut = !outValid_q || out_ready;

    // Round-robin search over pending channels, starting just after the last grant.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = lastGrant_q;
        searchIdx  = 0;
        for (int i = 0; i < N_CH; i++) begin
            searchIdx = (int'(lastGrant_q) + 1 + i) % N_CH;
            if (!grantFound && state_q[searchIdx] == ST_PEND) begin
                grantFound = 1'b1;
                grantIdx   = CH_W'(searchIdx);
            end
        end
    end

    always_comb begin
        dropVec = '0;
        dropPop = '0;
        for (int k = 0; k < N_CH; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            hold_d[k]  = hold_q[k];
            dropVec[k] = hitRise[k] && !clr && (state_q[k] != ST_IDLE);
            dropPop    = dropPop + 5'(dropVec[k]);
            if (clr) begin
                state_d[k] = ST_IDLE;
            end else begin
                case (state_q[k])
                    ST_IDLE: begin
                        if (hitRise[k]) begin
                            state_d[k] = ST_SETTLE;
                            cnt_d[k]   = '0;
                        end
                    end
                    ST_SETTLE: begin
                        cnt_d[k] = cnt_q[k] + 8'd1;
                        if (cnt_q[k] == CAPTURE_CNT) begin
                            hold_d[k]  = {coarse[k*W_DEC +: W_DEC],
                                          start_edge[k*W_DEC +: W_DEC],
                                          fall_edge[k*W_DEC +: W_DEC]};
                            state_d[k] = ST_PEND;
                        end
                    end
                    ST_PEND: begin
                        if (loadOut && grantFound && grantIdx == CH_W'(k)) begin
                            state_d[k] = ST_IDLE;
                        end
                    end
                    default: state_d[k] = ST_IDLE;
                endcase
            end
        end
    end

    // Output register: refill whenever the current word is empty or being consumed.
    always_comb begin
        outData_d   = outData_q;
        outValid_d  = outValid_q;
        lastGrant_d = lastGrant_q;
        dropSum     = {1'b0, dropCnt_q} + 17'(dropPop);
        dropCnt_d   = dropSum[16] ? 16'hFFFF : dropSum[15:0];
        if (clr) begin
            outValid_d  = 1'b0;
            dropCnt_d   = '0;
            lastGrant_d = LAST_RESET;
        end else if (loadOut) begin
            if (grantFound) begin
                outData_d   = {grantIdx, hold_q[grantIdx]};
                outValid_d  = 1'b1;
                lastGrant_d = grantIdx;
            end else begin
                outValid_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_CH; k++) begin
                state_q[k] <= ST_IDLE;
                cnt_q[k]   <= '0;
                hold_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
                hold_q[k]  <= hold_d[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outData_q   <= '0;
            outValid_q  <= 1'b0;
            dropCnt_q   <= '0;
            lastGrant_q <= LAST_RESET;
        end else begin
            outData_q   <= outData_d;
            outValid_q  <= outValid_d;
            dropCnt_q   <= dropCnt_d;
            lastGrant_q <= lastGrant_d;
        end
    end

    assign out_data  = outData_q;
    assign out_valid = outValid_q;
    assign drop_cnt  = dropCnt_q;

endmodule

// File: tb/tb_tdc_hit_merger.sv
// Directed testbench for tdc_hit_merger: table of single-hit vectors plus hand-written
// sequences for simultaneous hits, back-pressure, overrun, saturation and clear/reset.
module tb_tdc_hit_merger;

    localparam int N_CH   = 4;
    localparam int W_DEC  = 8;
    localparam int SETTLE = 15;
    localparam int W_OUT  = 2 + 3 * W_DEC;
    // Two synchronizer edges plus the SETTLE-entry edge, then SETTLE+1 to a valid output.
    localparam int LAT    = 3 + SETTLE + 1;

    typedef struct {
        int               ch;
        logic [7:0]       c;
        logic [7:0]       s;
        logic [7:0]       f;
        logic [W_OUT-1:0] exp;
    } vec_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  clr = 1'b0;
    logic [N_CH-1:0]       hit = '0;
    logic [N_CH*W_DEC-1:0] fall_edge = '0;
    logic [N_CH*W_DEC-1:0] start_edge = '0;
    logic [N_CH*W_DEC-1:0] coarse = '0;
    logic [W_OUT-1:0]      out_data;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic [15:0]           drop_cnt;

    int compared   = 0;
    int mismatched = 0;

    tdc_hit_merger #(.N_CH(N_CH), .W_DEC(W_DEC), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .clr(clr), .hit(hit),
        .fall_edge(fall_edge), .start_edge(start_edge), .coarse(coarse),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, compared=%0d", compared);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic setBus(input int ch, input logic [7:0] c, input logic [7:0] s,
                          input logic [7:0] f);
        coarse[ch*W_DEC +: W_DEC]     = c;
        start_edge[ch*W_DEC +: W_DEC] = s;
        fall_edge[ch*W_DEC +: W_DEC]  = f;
    endtask

    // Raise the masked hit bits for two cycles, returning on the negedge they drop.
    task automatic pulseHit(input logic [N_CH-1:0] mask);
        @(negedge clk);
        hit = hit | mask;
        @(negedge clk);
        @(negedge clk);
        hit = hit & ~mask;
    endtask

    task automatic waitValid(input int bound, output int cycles);
        cycles = -1;
        for (int c = 1; c <= bound; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                cycles = c;
                break;
            end
        end
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One single-hit vector: returns latency in edges from the first edge seeing the hit.
    task automatic applyStimulus(input vec_t v, output int lat);
        logic [N_CH-1:0] m;
        int c;
        m = '0;
        m[v.ch] = 1'b1;
        setBus(v.ch, v.c, v.s, v.f);
        pulseHit(m);
        waitValid(40, c);
        lat = (c < 0) ? -1 : c + 2;
    endtask

    initial begin
        vec_t vecs [4];
        int   lat;
        int   c;
        int   extra;

        vecs[0] = '{2, 8'hA5, 8'h3C, 8'h0F, {2'd2, 8'hA5, 8'h3C, 8'h0F}};
        vecs[1] = '{0, 8'h11, 8'h22, 8'h33, {2'd0, 8'h11, 8'h22, 8'h33}};
        vecs[2] = '{3, 8'hFF, 8'h00, 8'h80, {2'd3, 8'hFF, 8'h00, 8'h80}};
        vecs[3] = '{1, 8'h5A, 8'hC3, 8'h01, {2'd1, 8'h5A, 8'hC3, 8'h01}};

        for (int k = 0; k < N_CH; k++) begin
            setBus(k, 8'hE0 + 8'(k), 8'hD0 + 8'(k), 8'hB0 + 8'(k));
        end

        #12;
        checkOutput("reset_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_data", 64'(out_data), 64'd0);
        checkOutput("reset_drop", 64'(drop_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] single-hit vectors");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i], lat);
            checkOutput("single_lat", 64'(lat), 64'(LAT));
            checkOutput("single_data", 64'(out_data), 64'(vecs[i].exp));
            @(posedge clk);
            #1;
            checkOutput("single_valid_drop", 64'(out_valid), 64'd0);
        end
        checkOutput("single_drop_cnt", 64'(drop_cnt), 64'd0);

        $display("[TB] simultaneous hits");
        applyReset();
        setBus(0, 8'h10, 8'h20, 8'h30);
        setBus(1, 8'h41, 8'h52, 8'h63);
        setBus(3, 8'h9A, 8'hBC, 8'hDE);
        pulseHit(4'b1011);
        waitValid(40, c);
        checkOutput("simul_lat", 64'((c < 0) ? -1 : c + 2), 64'(LAT));
        checkOutput("simul_data0", 64'(out_data), 64'({2'd0, 8'h10, 8'h20, 8'h30}));
        @(posedge clk);
        #1;
        checkOutput("simul_valid1", 64'(out_valid), 64'd1);
        checkOutput("simul_data1", 64'(out_data), 64'({2'd1, 8'h41, 8'h52, 8'h63}));
        @(posedge clk);
        #1;
        checkOutput("simul_valid3", 64'(out_valid), 64'd1);
        checkOutput("simul_data3", 64'(out_data), 64'({2'd3, 8'h9A, 8'hBC, 8'hDE}));
        @(posedge clk);
        #1;
        checkOutput("simul_valid_end", 64'(out_valid), 64'd0);
        checkOutput("simul_drop", 64'(drop_cnt), 64'd0);

        $display("[TB] back-pressure");
        @(negedge clk);
        out_ready = 1'b0;
        setBus(1, 8'h81, 8'h42, 8'h24);
        setBus(2, 8'h18, 8'h7E, 8'hE7);
        pulseHit(4'b0110);
        waitValid(40, c);
        checkOutput("bp_lat", 64'((c < 0) ? -1 : c + 2), 64'(LAT));
        checkOutput("bp_data_first", 64'(out_data), 64'({2'd1, 8'h81, 8'h42, 8'h24}));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
            checkOutput("bp_hold_data", 64'(out_data), 64'({2'd1, 8'h81, 8'h42, 8'h24}));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_valid_second", 64'(out_valid), 64'd1);
        checkOutput("bp_data_second", 64'(out_data), 64'({2'd2, 8'h18, 8'h7E, 8'hE7}));
        @(posedge clk);
        #1;
        checkOutput("bp_valid_end", 64'(out_valid), 64'd0);
        checkOutput("bp_drop", 64'(drop_cnt), 64'd0);

        $display("[TB] overrun");
        @(negedge clk);
        out_ready = 1'b0;
        setBus(0, 8'hC0, 8'hC1, 8'hC2);
        setBus(1, 8'hD0, 8'hD1, 8'hD2);
        pulseHit(4'b0011);
        repeat (2) @(negedge clk);
        pulseHit(4'b0010);
        waitValid(60, c);
        checkOutput("ovr_data_ch0", 64'(out_data), 64'({2'd0, 8'hC0, 8'hC1, 8'hC2}));
        for (int i = 0; i < 3; i++) begin
            pulseHit(4'b0010);
            @(negedge clk);
        end
        repeat (6) @(negedge clk);
        checkOutput("ovr_drop_pend", 64'(drop_cnt), 64'd4);
        checkOutput("ovr_hold_data", 64'(out_data), 64'({2'd0, 8'hC0, 8'hC1, 8'hC2}));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ovr_valid_ch1", 64'(out_valid), 64'd1);
        checkOutput("ovr_data_ch1", 64'(out_data), 64'({2'd1, 8'hD0, 8'hD1, 8'hD2}));
        @(posedge clk);
        #1;
        checkOutput("ovr_valid_end", 64'(out_valid), 64'd0);
        extra = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid) extra++;
        end
        checkOutput("ovr_extra_results", 64'(extra), 64'd0);
        checkOutput("ovr_drop_final", 64'(drop_cnt), 64'd4);

        $display("[TB] saturation");
        applyReset();
        out_ready = 1'b0;
        pulseHit(4'hF);
        waitValid(40, c);
        checkOutput("sat_first_data_id", 64'(out_data[W_OUT-1 -: 2]), 64'd0);
        pulseHit(4'h1);
        repeat (25) @(negedge clk);
        checkOutput("sat_drop_start", 64'(drop_cnt), 64'd0);
        for (int i = 0; i < 16000; i++) begin
            @(negedge clk);
            hit = 4'hF;
            @(negedge clk);
            hit = 4'h0;
        end
        repeat (5) @(negedge clk);
        checkOutput("sat_drop_mid", 64'(drop_cnt), 64'hFA00);
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            hit = 4'hF;
            @(negedge clk);
            hit = 4'h0;
        end
        repeat (5) @(negedge clk);
        checkOutput("sat_drop_final", 64'(drop_cnt), 64'hFFFF);
        checkOutput("sat_valid_held", 64'(out_valid), 64'd1);

        $display("[TB] clear and reset mid-settle");
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checkOutput("clr_drop", 64'(drop_cnt), 64'd0);
        checkOutput("clr_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        setBus(0, 8'h77, 8'h88, 8'h99);
        pulseHit(4'h1);
        repeat (8) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        waitValid(40, c);
        checkOutput("clr_no_output", 64'(c), 64'hFFFF_FFFF_FFFF_FFFF);
        pulseHit(4'h1);
        waitValid(40, c);
        checkOutput("clr_after_lat", 64'((c < 0) ? -1 : c + 2), 64'(LAT));
        checkOutput("clr_after_data", 64'(out_data), 64'({2'd0, 8'h77, 8'h88, 8'h99}));
        checkOutput("clr_after_drop", 64'(drop_cnt), 64'd0);

        repeat (3) @(negedge clk);
        pulseHit(4'h1);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        waitValid(40, c);
        checkOutput("rst_no_output", 64'(c), 64'hFFFF_FFFF_FFFF_FFFF);
        pulseHit(4'h1);
        waitValid(40, c);
        checkOutput("rst_after_lat", 64'((c < 0) ? -1 : c + 2), 64'(LAT));
        checkOutput("rst_after_data", 64'(out_data), 64'({2'd0, 8'h77, 8'h88, 8'h99}));
        checkOutput("rst_after_drop", 64'(drop_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
